// File: rtl/prelu_act_cell.sv
// Fixed-point pass / ReLU / Leaky-ReLU / PReLU activation cell with optional upper clip,
// round-half-up requantisation and saturation, driving an external two-stage signed multiplier.
module prelu_act_cell #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALPHA_WIDTH      = 16,
  parameter int CH_N             = 16,
  parameter int INFO_ALONG_WIDTH = 2,
  parameter int SIM_DELAY        = 1
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic                                     aclken,
  input  logic [1:0]                               act_mode,
  input  logic [4:0]                               fixed_point_quat_accrc,
  input  logic signed [ALPHA_WIDTH-1:0]            act_param_alpha,
  input  logic                                     clip_en,
  input  logic signed [DATA_WIDTH-1:0]             clip_max,
  input  logic                                     alpha_wen,
  input  logic [$clog2(CH_N)-1:0]                  alpha_waddr,
  input  logic signed [ALPHA_WIDTH-1:0]            alpha_wdata,
  input  logic signed [DATA_WIDTH-1:0]             act_cell_i_op_x,
  input  logic [7:0]                               act_cell_i_ch_id,
  input  logic                                     act_cell_i_pass,
  input  logic [INFO_ALONG_WIDTH-1:0]              act_cell_i_info_along,
  input  logic                                     act_cell_i_vld,
  output logic signed [DATA_WIDTH-1:0]             act_cell_o_res,
  output logic [INFO_ALONG_WIDTH-1:0]              act_cell_o_info_along,
  output logic                                     act_cell_o_sat,
  output logic                                     act_cell_o_vld,
  output logic signed [DATA_WIDTH-1:0]             mul_op_a,
  output logic signed [ALPHA_WIDTH-1:0]            mul_op_b,
  output logic [1:0]                               mul_ce,
  input  logic signed [DATA_WIDTH+ALPHA_WIDTH-1:0] mul_res
);

  localparam int IDX_W = $clog2(CH_N);
  localparam int PW    = DATA_WIDTH + ALPHA_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_LEAKY = 2'b10,
    MODE_PRELU = 2'b11
  } act_mode_e;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0]  x;
    act_mode_e                     mode;
    logic                          pass;
    logic [INFO_ALONG_WIDTH-1:0]   info;
  } sample_t;

  logic signed [ALPHA_WIDTH-1:0] alpha_tbl [CH_N];
  logic signed [ALPHA_WIDTH-1:0] alpha_sel;
  sample_t                       s1, s2;
  logic                          s1_vld, s2_vld;

  // SIM_DELAY is kept only for parameter compatibility with the sibling activation cells.
  logic unused_sim_delay;
  assign unused_sim_delay = (SIM_DELAY != 0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alpha_sel = act_param_alpha;
    if (act_mode_e'(act_mode) == MODE_PRELU && int'(act_cell_i_ch_id) < CH_N)
      alpha_sel = alpha_tbl[act_cell_i_ch_id[IDX_W-1:0]];
  end

  assign mul_op_a = act_cell_i_op_x;
  assign mul_op_b = alpha_sel;
  assign mul_ce   = {aclken & s1_vld, aclken & act_cell_i_vld};

  // Sample fields ride alongside the multiplier's input and product registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1     <= '0;
      s2     <= '0;
    end else if (aclken) begin
      s1_vld <= act_cell_i_vld;
      s2_vld <= s1_vld;
      if (act_cell_i_vld)
        s1 <= '{x: act_cell_i_op_x, mode: act_mode_e'(act_mode),
                pass: act_cell_i_pass, info: act_cell_i_info_along};
      if (s1_vld)
        s2 <= s1;
    end
  end

  // An out-of-range write address cannot be expressed: the port is exactly clog2(CH_N) bits.
  // NOTE: the alpha table is reset because a cleared table is visible to software, so it is built from flops rather than a RAM.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < CH_N; i++) alpha_tbl[i] <= '0;
    end else if (aclken && alpha_wen) begin
      alpha_tbl[alpha_waddr] <= alpha_wdata;
    end
  end

  logic                          bypass;
  logic signed [PW:0]            prod_ext, rnd, shifted;
  logic signed [DATA_WIDTH-1:0]  res_c;
  logic                          sat_c;

  always_comb begin
    bypass   = s2.pass || (s2.mode == MODE_PASS);
    prod_ext = {mul_res[PW-1], mul_res};
    rnd      = '0;
    if (fixed_point_quat_accrc != 5'd0)
      rnd = {{PW{1'b0}}, 1'b1} << (fixed_point_quat_accrc - 5'd1);
    shifted  = (prod_ext + rnd) >>> fixed_point_quat_accrc;
    res_c    = s2.x;
    sat_c    = 1'b0;
    if (!bypass && s2.x[DATA_WIDTH-1]) begin
      if (s2.mode == MODE_RELU) begin
        res_c = '0;
      end else if (shifted[PW:DATA_WIDTH-1] != {(PW-DATA_WIDTH+2){shifted[PW]}}) begin
        res_c = shifted[PW] ? RES_MIN : RES_MAX;
        sat_c = 1'b1;
      end else begin
        res_c = shifted[DATA_WIDTH-1:0];
      end
    end
    if (!bypass && clip_en && res_c > clip_max) begin
      res_c = clip_max;
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      act_cell_o_vld        <= 1'b0;
      act_cell_o_res        <= '0;
      act_cell_o_sat        <= 1'b0;
      act_cell_o_info_along <= '0;
    end else if (aclken) begin
      act_cell_o_vld <= s2_vld;
      if (s2_vld) begin
        act_cell_o_res        <= res_c;
        act_cell_o_sat        <= sat_c;
        act_cell_o_info_along <= s2.info;
      end
    end
  end

endmodule

// File: doc/prelu_act_cell.md
Name: prelu_act_cell

Overview:
Parametrised fixed-point activation cell for the conv post-processing path. Supports pass, ReLU, Leaky-ReLU with a shared alpha, and PReLU with a per-channel alpha table. Adds optional upper clipping (ReLU6-style), round-half-up requantisation and saturation. Uses the same external two-stage signed multiplier interface as the existing activation cells and is fully pipelined at one sample per cycle.

Parameters:
DATA_WIDTH, 32, signed operand/result width (16 or 32)
ALPHA_WIDTH, 16, signed alpha width
CH_N, 16, PReLU alpha table depth (power of 2, >=2)
INFO_ALONG_WIDTH, 2, side-band width carried with each sample
SIM_DELAY, 1, register update delay for simulation

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
aclken  in  1  global clock enable; low freezes all state
act_mode  in  2  00 pass, 01 ReLU, 10 Leaky (shared alpha), 11 PReLU (table alpha)
fixed_point_quat_accrc  in  5  Q, alpha fractional bits, 0..ALPHA_WIDTH-1
act_param_alpha  in  ALPHA_WIDTH  shared signed alpha
clip_en  in  1  enable upper clip
clip_max  in  DATA_WIDTH  signed clip bound
alpha_wen  in  1  table write strobe
alpha_waddr  in  clog2(CH_N)  table write address
alpha_wdata  in  ALPHA_WIDTH  table write data
act_cell_i_op_x  in  DATA_WIDTH  signed operand X
act_cell_i_ch_id  in  8  channel index for PReLU
act_cell_i_pass  in  1  bypass activation and clip for this sample
act_cell_i_info_along  in  INFO_ALONG_WIDTH  side-band
act_cell_i_vld  in  1  input valid
act_cell_o_res  out  DATA_WIDTH  result
act_cell_o_info_along  out  INFO_ALONG_WIDTH  side-band, aligned with result
act_cell_o_sat  out  1  saturation or clip occurred
act_cell_o_vld  out  1  output valid
mul_op_a  out  DATA_WIDTH  multiplier operand (X)
mul_op_b  out  ALPHA_WIDTH  multiplier operand (alpha)
mul_ce  out  2  [0] input-register enable, [1] multiply-stage enable
mul_res  in  DATA_WIDTH+ALPHA_WIDTH  product, valid the cycle after the mul_ce[1] edge

Behaviour:
- Reset: all valids 0; o_res, o_info_along and o_sat are 0; alpha table is all 0; mul_ce is 0.
- No backpressure. A sample is accepted on each aclk edge with aclken=1 and i_vld=1.
- Latency is 3 enabled edges from accept to o_vld=1. Throughput is 1 sample per cycle.
- aclken=0: no state changes, mul_ce=0, outputs hold. Any number of stall cycles produces no loss and no duplicates.
- Alpha select: mode 11 with ch_id<CH_N uses table[ch_id]. Mode 11 with ch_id>=CH_N uses act_param_alpha. Mode 10 uses act_param_alpha.
- Multiplier drive: mul_op_a=i_op_x and mul_op_b=the selected alpha, both combinational from the inputs.
  - mul_ce[0]=aclken & i_vld.
  - mul_ce[1]=aclken & stage1 valid.
  - X, sign, mode, pass and side-band travel in a matching 2-stage delay line.
- Stage 3 computes the result from mul_res and the delayed X:
  - pass=1 or mode 00: res=X; clip bypassed; sat=0.
  - X>=0 (any non-pass mode): res=X.
  - X<0, mode 01: res=0.
  - X<0, mode 10/11: p=mul_res; if Q>0, p+=2^(Q-1); p>>>=Q (arithmetic shift). This is round-half-up. Then saturate to DATA_WIDTH signed; sat=1 if clamped.
  - Clip (clip_en=1, not pass): if res>clip_max then res=clip_max and sat=1.
- Table write:
  - Occurs on an enabled edge with alpha_wen=1.
  - alpha_waddr>=CH_N is ignored.
  - A read of the same entry on the same edge returns the old value. The new value applies to samples accepted on later edges.
- Configuration inputs (mode, Q, alphas, clip) must be static while any sample is in flight. Behaviour otherwise is undefined.
- Reset asserted mid-operation discards in-flight samples; o_vld drops asynchronously.

Test Plan:
- DATA_WIDTH=32, mode 10, Q=8, alpha=64; inputs 40, -40, -803, 0 back-to-back -> outputs 40, -10, -201, 0 on 4 consecutive cycles, 3 cycles after each input, sat=0, info_along preserved.
- mode 01, inputs -803, 803 -> 0, 803. Then pass=1 with x=-803 in mode 10 -> -803, sat=0.
- mode 11, Q=8: write table[3]=128 and table[5]=-64. Input x=-7 ch3 -> -3 (-3.5 rounds half up). x=-8 ch5 -> 2. ch_id=20 with shared alpha=64, x=-40 -> -10.
- Saturation: mode 10, Q=0, alpha=-32768, x=-2^31 -> 0x7FFFFFFF, sat=1.
- Clip: clip_en=1, clip_max=100, mode 01; x=500 -> 100, sat=1; x=50 -> 50, sat=0; pass=1 with x=500 -> 500.
- Stall/reset: drop aclken for 2 cycles mid-stream -> outputs delayed by 2 cycles, none duplicated. Assert aresetn with 2 samples in flight -> o_vld=0 immediately, table cleared, no stale output after release.
